// File: rtl/utmi_tx_packetizer.sv
// Stream-to-UTMI+ transmit packetizer: opmode switching, USB CRC16 append, inter-packet gap, stall abort.
// Latency: accepted byte is on O_fe_data/O_fe_txvalid one fe_clk later; first txvalid pSETTLE_CYCLES after opmode=00.
// Backpressure: O_data_ready follows the one-byte holding register (free or draining via fe_txrdy); stalls abort on timeout.
module utmi_tx_packetizer #(
    parameter int pSETTLE_CYCLES = 4,
    parameter int pTIMEOUT_WIDTH = 12,
    parameter int pIPG_WIDTH     = 8
) (
    input  logic                  fe_clk,
    input  logic                  reset_i,
    input  logic [7:0]            I_data,
    input  logic                  I_data_valid,
    input  logic                  I_data_last,
    output logic                  O_data_ready,
    input  logic                  I_crc_enable,
    input  logic [pIPG_WIDTH-1:0] I_ipg_cycles,
    input  logic                  fe_txrdy,
    output logic [7:0]            O_fe_data,
    output logic                  O_fe_txvalid,
    output logic [1:0]            O_opmode,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP, S_FLUSH
    } state_t;

    // SETTLE covers all but the last settle cycle; the PID-accept cycle supplies that one.
    localparam logic [7:0] SETTLE_LAST = 8'((pSETTLE_CYCLES > 1) ? pSETTLE_CYCLES - 2 : 0);
    localparam logic [pTIMEOUT_WIDTH-1:0] STALL_LAST = {{(pTIMEOUT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [pIPG_WIDTH-1:0] IPG_ONE = {{(pIPG_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state, state_nxt;
    logic [7:0]                hold_data;
    logic                      hold_valid;
    logic                      last_seen;
    logic                      is_data;
    logic [15:0]               crc;
    logic [7:0]                settle_cnt;
    logic [pTIMEOUT_WIDTH-1:0] stall_cnt;
    logic [pIPG_WIDTH-1:0]     gap_cnt;
    logic                      hs;
    logic                      stall_fire;
    logic                      accept;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    assign hs         = hold_valid && fe_txrdy;
    assign stall_fire = hold_valid && !fe_txrdy && (stall_cnt == STALL_LAST);
    assign accept     = I_data_valid && O_data_ready;
    assign O_fe_data    = hold_data;
    assign O_fe_txvalid = hold_valid;

    always_ff @(posedge fe_clk) begin
        if (!reset_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        O_data_ready = 1'b0;
        O_opmode     = 2'b01;
        O_busy       = (state != S_IDLE);
        case (state)
            S_IDLE:
                if (I_data_valid) state_nxt = (pSETTLE_CYCLES == 1) ? S_PID : S_SETTLE;
            S_SETTLE: begin
                O_opmode = 2'b00;
                if (settle_cnt == SETTLE_LAST) state_nxt = S_PID;
            end
            S_PID: begin
                O_opmode     = 2'b00;
                O_data_ready = !hold_valid || fe_txrdy;
                if (accept) state_nxt = S_DATA;
            end
            S_DATA: begin
                O_opmode     = 2'b00;
                O_data_ready = !last_seen && (!hold_valid || fe_txrdy);
                if (stall_fire)
                    state_nxt = last_seen ? S_GAP : S_FLUSH;
                else if (last_seen && hs)
                    state_nxt = is_data ? S_CRC_LO : S_GAP;
            end
            S_CRC_LO: begin
                O_opmode = 2'b00;
                if (stall_fire)  state_nxt = S_GAP;
                else if (hs)     state_nxt = S_CRC_HI;
            end
            S_CRC_HI: begin
                O_opmode = 2'b00;
                if (stall_fire || hs) state_nxt = S_GAP;
            end
            S_GAP:
                if (gap_cnt <= IPG_ONE) state_nxt = S_IDLE;
            S_FLUSH: begin
                O_data_ready = 1'b1;
                if (I_data_valid && I_data_last) state_nxt = S_GAP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
            last_seen  <= 1'b0;
            is_data    <= 1'b0;
            crc        <= 16'hFFFF;
            settle_cnt <= 8'h00;
            stall_cnt  <= '0;
            gap_cnt    <= '0;
            O_done     <= 1'b0;
            O_timeout  <= 1'b0;
        end else begin
            O_done     <= 1'b0;
            O_timeout  <= stall_fire;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'h00;
            if (hold_valid && !fe_txrdy && !stall_fire) stall_cnt <= stall_cnt + 1'b1;
            else                                        stall_cnt <= '0;
            if (state == S_IDLE) begin
                crc       <= 16'hFFFF;
                last_seen <= 1'b0;
            end
            if (accept && (state == S_PID || state == S_DATA)) begin
                hold_data  <= I_data;
                hold_valid <= 1'b1;
                if (I_data_last) last_seen <= 1'b1;
                if (state == S_PID)
                    is_data <= I_crc_enable && (I_data inside {8'hC3, 8'h4B, 8'h87, 8'h0F});
                else
                    crc <= crc16_byte(crc, I_data);
            end else if (stall_fire) begin
                hold_valid <= 1'b0;
            end else if (hs) begin
                case (state)
                    S_DATA:
                        if (last_seen && is_data) begin
                            hold_data <= ~crc[7:0];
                        end else begin
                            hold_valid <= 1'b0;
                            O_done     <= last_seen;
                        end
                    S_CRC_LO: hold_data <= ~crc[15:8];
                    S_CRC_HI: begin
                        hold_valid <= 1'b0;
                        O_done     <= 1'b1;
                    end
                    default: hold_valid <= 1'b0;
                endcase
            end
            // I_ipg_cycles is captured once on GAP entry; zero still yields one gap cycle.
            if (state_nxt == S_GAP && state != S_GAP)
                gap_cnt <= (I_ipg_cycles == '0) ? IPG_ONE : I_ipg_cycles;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule
